// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types, defaults and the default melody for the tone sequencer
package tone_pkg;

  localparam logic [31:0] AMPLITUDE_DEF = 32'h1000_0000;
  localparam int          NUM_NOTES_DEF = 16;

  typedef struct packed {
    logic [7:0]  half_period;
    logic [15:0] duration;
    logic        last;
  } note_t;

  typedef note_t [NUM_NOTES_DEF-1:0] melody_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_DONE
  } state_t;

  // Half periods assume a 48 kHz sample rate; durations are quarter/half seconds.
  function automatic melody_t default_melody();
    melody_t m;
    m = '0;
    m[0] = '{half_period: 8'd92, duration: 16'd12000, last: 1'b0};
    m[1] = '{half_period: 8'd82, duration: 16'd12000, last: 1'b0};
    m[2] = '{half_period: 8'd73, duration: 16'd12000, last: 1'b0};
    m[3] = '{half_period: 8'd69, duration: 16'd12000, last: 1'b0};
    m[4] = '{half_period: 8'd61, duration: 16'd12000, last: 1'b0};
    m[5] = '{half_period: 8'd0,  duration: 16'd6000,  last: 1'b0};
    m[6] = '{half_period: 8'd92, duration: 16'd24000, last: 1'b1};
    return m;
  endfunction

  localparam melody_t DEFAULT_MELODY = default_melody();

endpackage

// File: rtl/tone_sequencer_if.sv
// rtl/tone_sequencer_if.sv - sample/write handshake toward the Audio_Controller
interface tone_sequencer_if;

  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );

endinterface

// File: rtl/tone_table.sv
// rtl/tone_table.sv - melody ROM with a one-cycle registered read
module tone_table
  import tone_pkg::*;
#(
  parameter int                    NUM_NOTES = NUM_NOTES_DEF,
  parameter note_t [NUM_NOTES-1:0] MELODY    = DEFAULT_MELODY
) (
  input  logic                         clk,
  input  logic [$clog2(NUM_NOTES)-1:0] addr,
  output note_t                        data
);

  note_t data_q;
  note_t data_d;

  always_comb begin
    data_d = MELODY[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - steps through the melody ROM and writes square-wave samples
module tone_sequencer
  import tone_pkg::*;
#(
  parameter logic [31:0]           AMPLITUDE = AMPLITUDE_DEF,
  parameter int                    NUM_NOTES = NUM_NOTES_DEF,
  parameter note_t [NUM_NOTES-1:0] MELODY    = DEFAULT_MELODY
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  tone_sequencer_if.master             audio,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_NOTES)-1:0] note_index
);

  localparam int            IW       = $clog2(NUM_NOTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NOTES - 1);
  localparam logic [31:0]   NEG_AMP  = ~AMPLITUDE + 32'd1;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  note_t         note_q, note_d;
  logic [7:0]    phase_q, phase_d;
  logic [15:0]   dur_q, dur_d;
  logic          pol_q, pol_d;
  logic [31:0]   sample_q, sample_d;
  logic          done_q, done_d;
  note_t         rom_data;
  logic          wr;
  logic [15:0]   dur_last;

  // The ROM is addressed with the next index so the entry is ready by the end of LOAD.
  tone_table #(
    .NUM_NOTES (NUM_NOTES),
    .MELODY    (MELODY)
  ) u_table (
    .clk  (CLOCK_50),
    .addr (idx_d),
    .data (rom_data)
  );

  assign wr       = (state_q == ST_PLAY) && audio.audio_out_allowed;
  assign dur_last = (note_q.duration == 16'd0) ? 16'd0 : note_q.duration - 16'd1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      note_q   <= '0;
      phase_q  <= '0;
      dur_q    <= '0;
      pol_q    <= 1'b0;
      sample_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
      phase_q  <= phase_d;
      dur_q    <= dur_d;
      pol_q    <= pol_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    note_d   = note_q;
    phase_d  = phase_q;
    dur_d    = dur_q;
    pol_d    = pol_q;
    sample_d = sample_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sample_d = '0;
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d  = ST_PLAY;
        note_d   = rom_data;
        phase_d  = '0;
        dur_d    = '0;
        pol_d    = 1'b1;
        sample_d = (rom_data.half_period == 8'd0) ? '0 : AMPLITUDE;
      end
      ST_PLAY: begin
        if (wr) begin
          // The toggling write still carries the old sample; the new one lands on this edge.
          if (note_q.half_period != 8'd0) begin
            if (phase_q == note_q.half_period - 8'd1) begin
              phase_d  = '0;
              pol_d    = ~pol_q;
              sample_d = pol_q ? NEG_AMP : AMPLITUDE;
            end else begin
              phase_d = phase_q + 8'd1;
            end
          end
          if (dur_q == dur_last) begin
            if (note_q.last) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
              idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
          end else begin
            dur_d = dur_q + 16'd1;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        done_d   = 1'b1;
        sample_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d  = ST_IDLE;
      idx_d    = idx_q;
      sample_d = '0;
      done_d   = 1'b0;
    end
  end

  always_comb begin
    audio.write_audio_out         = wr;
    audio.left_channel_audio_out  = sample_q;
    audio.right_channel_audio_out = sample_q;
    busy                          = (state_q == ST_LOAD) || (state_q == ST_PLAY);
    done                          = done_q;
    note_index                    = idx_q;
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer against a note-level model
module tb_tone_sequencer;
  import tone_pkg::*;

  localparam logic [31:0] AMP  = 32'h1000_0000;
  localparam logic [31:0] NAMP = 32'hF000_0000;

  function automatic note_t nt(input int hp, input int dur, input bit lst);
    note_t n;
    n.half_period = 8'(hp);
    n.duration    = 16'(dur);
    n.last        = lst;
    return n;
  endfunction

  function automatic melody_t mel_a_f();
    melody_t m;
    m    = '0;
    m[0] = nt(2, 8, 1'b1);
    return m;
  endfunction

  function automatic melody_t mel_b_f();
    melody_t m;
    m    = '0;
    m[0] = nt(1, 3, 1'b0);
    m[1] = nt(0, 2, 1'b0);
    m[2] = nt(2, 8, 1'b0);
    m[3] = nt(3, 0, 1'b0);
    m[4] = nt(5, 100, 1'b0);
    m[5] = nt(4, 7, 1'b1);
    return m;
  endfunction

  localparam melody_t MEL_A = mel_a_f();
  localparam melody_t MEL_B = mel_b_f();

  logic        clk = 1'b0;
  logic        reset;
  logic        start_v   [2];
  logic        stop_v    [2];
  logic        allowed_v [2];
  logic        busy_v    [2];
  logic        done_v    [2];
  logic [3:0]  idx_v     [2];
  logic        wr_v      [2];
  logic [31:0] left_v    [2];
  logic [31:0] right_v   [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  melody_t     mel [2];
  logic [31:0] exp_s [$];
  int          exp_i [$];
  int          exp_notes;
  int          wr_per_note [16];

  tone_sequencer_if if_a ();
  tone_sequencer_if if_b ();

  assign if_a.audio_out_allowed = allowed_v[0];
  assign if_b.audio_out_allowed = allowed_v[1];
  assign wr_v[0]    = if_a.write_audio_out;
  assign wr_v[1]    = if_b.write_audio_out;
  assign left_v[0]  = if_a.left_channel_audio_out;
  assign left_v[1]  = if_b.left_channel_audio_out;
  assign right_v[0] = if_a.right_channel_audio_out;
  assign right_v[1] = if_b.right_channel_audio_out;

  tone_sequencer #(.MELODY(MEL_A)) dut_a (
    .CLOCK_50 (clk), .reset (reset), .start (start_v[0]), .stop (stop_v[0]),
    .audio (if_a.master), .busy (busy_v[0]), .done (done_v[0]), .note_index (idx_v[0])
  );

  tone_sequencer #(.MELODY(MEL_B)) dut_b (
    .CLOCK_50 (clk), .reset (reset), .start (start_v[1]), .stop (stop_v[1]),
    .audio (if_b.master), .busy (busy_v[1]), .done (done_v[1]), .note_index (idx_v[1])
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected write stream: one entry per sample, square wave derived from the sample number.
  task automatic build_expected(input int d);
    note_t n;
    int    dd;
    int    i;
    exp_s.delete();
    exp_i.delete();
    exp_notes = 0;
    i = 0;
    while (i < 16) begin
      n  = mel[d][i];
      dd = (n.duration == 16'd0) ? 1 : int'(n.duration);
      for (int k = 0; k < dd; k++) begin
        if (n.half_period == 8'd0) exp_s.push_back(32'd0);
        else exp_s.push_back(((k / int'(n.half_period)) % 2 == 0) ? AMP : NAMP);
        exp_i.push_back(i);
      end
      exp_notes++;
      if (n.last) break;
      i++;
    end
  endtask

  task automatic run_checked(input int d, input int mode);
    int pos, last_wr, first_wr, ndone, gaps, done_c, c;
    bit prev_busy;
    build_expected(d);
    pos = 0; last_wr = -10; first_wr = -1; ndone = 0; gaps = 0; done_c = 0; prev_busy = 1'b0;
    for (int n = 0; n < 16; n++) wr_per_note[n] = 0;
    for (c = 0; c < 3000; c++) begin
      next_cycle();
      start_v[d]   = (c == 0) || (mode == 2 && prev_busy && pos < exp_s.size() && $urandom_range(7) == 0);
      allowed_v[d] = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(3) != 0);
      #3;
      if (wr_v[d]) begin
        n_tests++;
        if (!allowed_v[d]) begin
          n_fail++;
          $display("FAIL write_without_allowed d=%0d c=%0d", d, c);
        end else if (pos >= exp_s.size()) begin
          n_fail++;
          $display("FAIL extra_write d=%0d c=%0d got=%h expected no write", d, c, left_v[d]);
        end else if (left_v[d] !== exp_s[pos] || right_v[d] !== exp_s[pos] || idx_v[d] !== exp_i[pos]) begin
          n_fail++;
          $display("FAIL write_data d=%0d w=%0d got=%h/%h idx=%0d expected=%h idx=%0d",
                   d, pos, left_v[d], right_v[d], idx_v[d], exp_s[pos], exp_i[pos]);
        end
        pos++;
        wr_per_note[idx_v[d]]++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end else if (busy_v[d] && allowed_v[d]) begin
        gaps++;
      end
      if (done_v[d]) begin
        n_tests++;
        ndone++;
        done_c = c;
        if (c != last_wr + 2 || pos != exp_s.size()) begin
          n_fail++;
          $display("FAIL done_timing d=%0d got c=%0d writes=%0d expected c=%0d writes=%0d",
                   d, c, pos, last_wr + 2, exp_s.size());
        end
      end
      prev_busy = busy_v[d];
      if (ndone > 0 && c >= done_c + 3) break;
    end
    start_v[d] = 1'b0;
    n_tests++;
    if (pos != exp_s.size() || ndone != 1) begin
      n_fail++;
      $display("FAIL run_totals d=%0d mode=%0d got writes=%0d dones=%0d expected writes=%0d dones=1",
               d, mode, pos, ndone, exp_s.size());
    end
    n_tests++;
    if (mode == 0 && (first_wr != 2 || gaps != exp_notes)) begin
      n_fail++;
      $display("FAIL load_gaps d=%0d got first=%0d gaps=%0d expected first=2 gaps=%0d", d, first_wr, gaps, exp_notes);
    end else if (mode != 0 && gaps > exp_notes) begin
      n_fail++;
      $display("FAIL load_gaps d=%0d got gaps=%0d expected at most %0d", d, gaps, exp_notes);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    allowed_v[0] = 1'b1;
    allowed_v[1] = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (wr_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 ||
          left_v[d] !== 32'd0 || right_v[d] !== 32'd0 || idx_v[d] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state d=%0d got wr=%b busy=%b done=%b l=%h r=%h idx=%0d expected all zero",
                 d, wr_v[d], busy_v[d], done_v[d], left_v[d], right_v[d], idx_v[d]);
      end
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_single_note();
    bit exp_wr, exp_done, exp_busy;
    build_expected(0);
    for (int c = 0; c < 14; c++) begin
      next_cycle();
      start_v[0]   = (c == 0);
      allowed_v[0] = 1'b1;
      #3;
      exp_wr   = (c >= 2 && c <= 9);
      exp_done = (c == 11);
      exp_busy = (c >= 1 && c <= 9);
      n_tests++;
      if (wr_v[0] !== exp_wr || done_v[0] !== exp_done || busy_v[0] !== exp_busy) begin
        n_fail++;
        $display("FAIL single_note_ctrl c=%0d got wr=%b done=%b busy=%b expected wr=%b done=%b busy=%b",
                 c, wr_v[0], done_v[0], busy_v[0], exp_wr, exp_done, exp_busy);
      end
      if (exp_wr) begin
        n_tests++;
        if (left_v[0] !== exp_s[c-2]) begin
          n_fail++;
          $display("FAIL single_note_sample c=%0d got=%h expected=%h", c, left_v[0], exp_s[c-2]);
        end
      end
    end
  endtask

  task automatic test_throttled();
    run_checked(0, 1);
  endtask

  task automatic test_two_notes();
    bit          ew [8] = '{0, 0, 1, 1, 1, 0, 1, 1};
    logic [31:0] es [8] = '{32'd0, 32'd0, AMP, NAMP, AMP, 32'd0, 32'd0, 32'd0};
    int          ei [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      start_v[1]   = (c == 0);
      allowed_v[1] = 1'b1;
      #3;
      n_tests++;
      if (wr_v[1] !== ew[c] || (ew[c] && left_v[1] !== es[c]) || (c >= 1 && idx_v[1] !== ei[c])) begin
        n_fail++;
        $display("FAIL two_notes c=%0d got wr=%b s=%h idx=%0d expected wr=%b s=%h idx=%0d",
                 c, wr_v[1], left_v[1], idx_v[1], ew[c], es[c], ei[c]);
      end
    end
    next_cycle();
    stop_v[1] = 1'b1;
    next_cycle();
    stop_v[1] = 1'b0;
    #3;
    n_tests++;
    if (busy_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL two_notes_abort got busy=%b expected 0", busy_v[1]);
    end
  endtask

  task automatic test_stop();
    int cnt4;
    bit hit;
    cnt4 = 0;
    hit  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      start_v[1]   = (c == 0);
      allowed_v[1] = 1'b1;
      stop_v[1]    = (cnt4 == 2);
      #3;
      if (stop_v[1]) begin
        hit = 1'b1;
        n_tests++;
        if (wr_v[1] !== 1'b1 || idx_v[1] !== 4'd4) begin
          n_fail++;
          $display("FAIL stop_third_write got wr=%b idx=%0d expected wr=1 idx=4", wr_v[1], idx_v[1]);
        end
        break;
      end
      if (wr_v[1] && idx_v[1] == 4'd4) cnt4++;
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL stop_timeout got %0d writes of note 4 expected 2", cnt4);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      stop_v[1] = 1'b0;
      #3;
      n_tests++;
      if (busy_v[1] !== 1'b0 || wr_v[1] !== 1'b0 || left_v[1] !== 32'd0 || done_v[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_idle k=%0d got busy=%b wr=%b s=%h done=%b expected 0,0,0,0",
                 k, busy_v[1], wr_v[1], left_v[1], done_v[1]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      start_v[1] = (c == 0);
      #3;
      if (c == 2) begin
        n_tests++;
        if (wr_v[1] !== 1'b1 || left_v[1] !== AMP || idx_v[1] !== 4'd0) begin
          n_fail++;
          $display("FAIL stop_replay got wr=%b s=%h idx=%0d expected wr=1 s=%h idx=0",
                   wr_v[1], left_v[1], idx_v[1], AMP);
        end
      end
    end
    next_cycle();
    stop_v[1] = 1'b1;
    next_cycle();
    stop_v[1] = 1'b0;
  endtask

  task automatic test_dur_zero();
    for (int r = 0; r < 3; r++) begin
      run_checked(1, 2);
      n_tests++;
      if (wr_per_note[3] != 1) begin
        n_fail++;
        $display("FAIL dur_zero_writes r=%0d got=%0d expected=1", r, wr_per_note[3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_checked(1, 0);
    run_checked(1, 0);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 21; c++) begin
      next_cycle();
      start_v[1]   = (c == 0);
      allowed_v[1] = 1'b1;
      reset        = (c == 20);
    end
    next_cycle();
    reset = 1'b0;
    #3;
    n_tests++;
    if (busy_v[1] !== 1'b0 || wr_v[1] !== 1'b0 || left_v[1] !== 32'd0 || idx_v[1] !== 4'd0 || done_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b wr=%b s=%h idx=%0d done=%b expected all zero",
               busy_v[1], wr_v[1], left_v[1], idx_v[1], done_v[1]);
    end
  endtask

  initial begin
    mel[0] = MEL_A;
    mel[1] = MEL_B;
    reset  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d]   = 1'b0;
      stop_v[d]    = 1'b0;
      allowed_v[d] = 1'b0;
    end
    test_reset();
    test_single_note();
    test_throttled();
    test_two_notes();
    test_stop();
    test_dur_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a fixed melody through the board's audio path. It steps through a note table and synthesises a square wave for each note. It drives the Audio_Controller's left/right sample inputs and `write_audio_out`, using `audio_out_allowed` as FIFO back-pressure. It sits beside the codec configuration block at the top level. It replaces a free-running oscillator when a timed sequence of tones is needed.

## Interface
- `AMPLITUDE`, 32'h1000_0000: positive sample value; the negative half-cycle is its two's complement.
- `NUM_NOTES`, 16: table depth; the index is `$clog2(NUM_NOTES)` bits wide.
- `CLOCK_50`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse; starts playback from entry 0. Ignored unless in IDLE.
- `stop`, in, 1: aborts playback; the block returns to IDLE on the next edge.
- `audio_out_allowed`, in, 1: Audio_Controller has FIFO space.
- `write_audio_out`, out, 1: a sample is written this cycle.
- `left_channel_audio_out`, out, 32: current sample.
- `right_channel_audio_out`, out, 32: identical to left.
- `busy`, out, 1: high in LOAD or PLAY.
- `done`, out, 1: one-cycle pulse when the last note completes.
- `note_index`, out, `$clog2(NUM_NOTES)`: index of the current entry.

## Operation
- Table entry fields:
  - `half_period`: 8 bits, counted in samples; 0 means rest.
  - `duration`: 16 bits, counted in samples; 0 is treated as 1.
  - `last`: 1 bit.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - Samples are 0, `write_audio_out` is 0.
  - `start` moves the block to LOAD with `note_index` set to 0.
- LOAD:
  - The ROM read for `note_index` is in flight; no writes occur.
  - Next state is PLAY.
  - On entering PLAY, latch the entry, clear the phase and duration counters, and set polarity to positive.
- PLAY:
  - `write_audio_out = audio_out_allowed`. This is the only combinational path; the sample registers must already be stable.
  - Each write advances the counters; cycles with `audio_out_allowed = 0` advance nothing.
  - Sample value: `+AMPLITUDE` when polarity is positive, `-AMPLITUDE` when negative, 0 for a rest.
  - Phase: on a write with `phase_cnt == half_period-1`, toggle polarity and clear `phase_cnt`; otherwise increment it. Rests never toggle.
  - Duration: on a write with `dur_cnt == max(duration,1)-1`:
    - if `last` = 0, `note_index` increments and the state goes to LOAD;
    - if `last` = 1, the state goes to DONE.
  - `note_index` wraps at `NUM_NOTES-1` back to 0 only if that entry's `last` is 0. The table should never rely on this.
- DONE:
  - Asserts `done` for one cycle, then goes to IDLE.
  - Samples return to 0.
- `stop` has priority over every transition except reset: the next state is IDLE, samples go to 0, and `done` is not pulsed.
- `start` in IDLE together with `stop`: `stop` wins and the block stays in IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `write_audio_out`, `busy` and `done` all 0;
  - samples 0;
  - `note_index` 0;
  - all counters 0.
- `start` at cycle 0: LOAD at cycle 1, PLAY at cycle 2. With `audio_out_allowed` held high, the first write is at cycle 2.
- Each note boundary costs one LOAD cycle with no write.
- Sample registers update on the edge after the write that changes polarity. The write that triggers a toggle still carries the old value.
- Reset taken in mid-note is immediate on the next edge; no partial note is resumed.

## Structure
- Package `tone_pkg` holds:
  - `note_t` struct (`half_period`, `duration`, `last`);
  - state enum;
  - the default melody constant array.
- Sub-module `tone_table`: a synchronous ROM indexed by `note_index` with a 1-cycle read (this is the reason for LOAD). Its contents come from `tone_pkg`.
- Top level holds the FSM, the phase/duration counters and the sample register.

## Test plan
- Reset while in PLAY → next cycle state is IDLE, samples 0, `write_audio_out` 0, `note_index` 0.
- Table {hp=2, dur=8, last=1}, `audio_out_allowed` held 1, `start` → writes at cycles 2–9 with samples +A,+A,−A,−A,+A,+A,−A,−A; `done` at cycle 11.
- Same table with `audio_out_allowed` toggling 1,0,1,0… → exactly 8 writes, same sample sequence; no counter advance on 0 cycles.
- Two notes {hp=1, dur=3}, {hp=0, dur=2, last=1} → +A,−A,+A, then one write-free LOAD cycle, then 0,0, then `done`; `note_index` shows 0 then 1.
- `stop` asserted during the third write of a 100-sample note → IDLE next cycle, no `done`, samples 0. A following `start` replays from entry 0.
- `duration=0` entry → exactly one write for that note; `start` pulses while busy are ignored.
